// File: rtl/l2_port_arbiter.sv
// Round-robin arbiter sharing the unified L2 request port between two L1 cache FSMs.
// Optional watchdog enabled by defining ARB_TIMEOUT_EN.
module l2_port_arbiter #(
    parameter int ADDRESS_WIDTH  = 32,
    parameter int LINE_WIDTH     = 128,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [ADDRESS_WIDTH-1:0] l1a_address,
    input  logic [ADDRESS_WIDTH-1:0] l1b_address,
    input  logic                     l1a_read_req,
    input  logic                     l1b_read_req,
    input  logic                     l1a_write_req,
    input  logic                     l1b_write_req,
    input  logic                     l1a_write_back_req,
    input  logic                     l1b_write_back_req,
    input  logic [LINE_WIDTH-1:0]    l1a_write_back_data,
    input  logic [LINE_WIDTH-1:0]    l1b_write_back_data,
    output logic [ADDRESS_WIDTH-1:0] l2_address,
    output logic                     l2_read_req,
    output logic                     l2_write_req,
    output logic                     l2_write_back_req,
    output logic [LINE_WIDTH-1:0]    l2_write_back_data,
    input  logic                     L2_ready,
    input  logic                     write_to_L2_verified,
    input  logic                     write_back_to_L2_verified,
    input  logic [LINE_WIDTH-1:0]    l2_read_data,
    output logic                     l1a_L2_ready,
    output logic                     l1b_L2_ready,
    output logic                     l1a_write_verified,
    output logic                     l1b_write_verified,
    output logic                     l1a_write_back_verified,
    output logic                     l1b_write_back_verified,
    output logic [LINE_WIDTH-1:0]    l1_read_data,
    output logic                     grant_id,
    output logic                     arb_busy,
    output logic                     timeout_error
);

    typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, RELEASE = 2'd2} state_t;
    typedef enum logic [1:0] {REQ_NONE, REQ_READ, REQ_WRITE, REQ_WB} req_t;

    state_t state_q, state_d;
    req_t   type_q, type_d;
    logic   rr_q, rr_d, grant_q, grant_d;
    logic   a_active, b_active, idle_pick;
    logic   sel_rd, sel_wr, sel_wb, held, strobe;
    logic   in_grant, done, timeout_hit;

    function automatic req_t pick_type(input logic rd, input logic wr, input logic wb);
        if (wb)      return REQ_WB;
        else if (wr) return REQ_WRITE;
        else if (rd) return REQ_READ;
        else         return REQ_NONE;
    endfunction

    assign a_active  = l1a_read_req | l1a_write_req | l1a_write_back_req;
    assign b_active  = l1b_read_req | l1b_write_req | l1b_write_back_req;
    assign idle_pick = (a_active && b_active) ? rr_q : b_active;

    // Reset gates the port so an aborted transaction routes nothing in the reset cycle.
    assign in_grant = (state_q == GRANT) && !reset;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        sel_rd = grant_q ? l1b_read_req       : l1a_read_req;
        sel_wr = grant_q ? l1b_write_req      : l1a_write_req;
        sel_wb = grant_q ? l1b_write_back_req : l1a_write_back_req;
        held   = 1'b0;
        strobe = 1'b0;
        case (type_q)
            REQ_READ:  begin held = sel_rd; strobe = L2_ready;                  end
            REQ_WRITE: begin held = sel_wr; strobe = write_to_L2_verified;      end
            REQ_WB:    begin held = sel_wb; strobe = write_back_to_L2_verified; end
            default:   ;
        endcase
    end

    assign done = in_grant && strobe;

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CNT_W-1:0] cnt_q;
    logic             timeout_q;

    // Counter holds the number of GRANT cycles already elapsed; the Nth cycle trips it.
    assign timeout_hit   = in_grant && !strobe && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign timeout_error = timeout_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q <= (state_q == GRANT) ? cnt_q + 1'b1 : '0;
            if (timeout_hit)
                timeout_q <= 1'b1;
        end
    end
`else
    assign timeout_hit   = 1'b0;
    assign timeout_error = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        grant_d = grant_q;
        type_d  = type_q;
        case (state_q)
            IDLE: begin
                if (a_active || b_active) begin
                    grant_d = idle_pick;
                    type_d  = idle_pick ? pick_type(l1b_read_req, l1b_write_req, l1b_write_back_req)
                                        : pick_type(l1a_read_req, l1a_write_req, l1a_write_back_req);
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (done || timeout_hit) begin
                    state_d = RELEASE;
                    rr_d    = ~grant_q;
                end else if (!held) begin
                    state_d = RELEASE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset) begin
            state_q <= IDLE;
            rr_q    <= 1'b0;
            grant_q <= 1'b0;
            type_q  <= REQ_NONE;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            grant_q <= grant_d;
            type_q  <= type_d;
        end
    end

    assign l2_read_req        = in_grant && (type_q == REQ_READ)  && sel_rd;
    assign l2_write_req       = in_grant && (type_q == REQ_WRITE) && sel_wr;
    assign l2_write_back_req  = in_grant && (type_q == REQ_WB)    && sel_wb;
    assign l2_address         = in_grant ? (grant_q ? l1b_address : l1a_address) : '0;
    assign l2_write_back_data = in_grant ? (grant_q ? l1b_write_back_data : l1a_write_back_data) : '0;

    assign l1a_L2_ready            = done && !grant_q && (type_q == REQ_READ);
    assign l1b_L2_ready            = done &&  grant_q && (type_q == REQ_READ);
    assign l1a_write_verified      = done && !grant_q && (type_q == REQ_WRITE);
    assign l1b_write_verified      = done &&  grant_q && (type_q == REQ_WRITE);
    assign l1a_write_back_verified = done && !grant_q && (type_q == REQ_WB);
    assign l1b_write_back_verified = done &&  grant_q && (type_q == REQ_WB);

    assign l1_read_data = l2_read_data;
    assign grant_id     = grant_q;
    assign arb_busy     = in_grant;

endmodule

// File: doc/l2_port_arbiter.md
Name: l2_port_arbiter

Overview:
- Shares the single request port of the unified L2 cache between the two L1 cache FSMs (L1a, core 0; L1b, core 1).
- Arbitrates read-allocate, inclusion-write and write-back requests round-robin and holds the grant until the L2 completes the transaction.
- Routes L2 responses back only to the granted L1, and forces a one-cycle idle gap on the L2 port between transactions.

Parameters:
ADDRESS_WIDTH, 32, request address width (bits [31:30] carry processor ID; passed through untouched)
LINE_WIDTH, 128, cache line width (MAIN_MEMORY_DATA_WIDTH)
TIMEOUT_CYCLES, 255, watchdog limit; used only with ARB_TIMEOUT_EN

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
l1a_address / l1b_address  in  ADDRESS_WIDTH  request address from L1a / L1b
l1a_read_req / l1b_read_req  in  1  read (allocate) request
l1a_write_req / l1b_write_req  in  1  inclusion-policy write request
l1a_write_back_req / l1b_write_back_req  in  1  dirty write-back request
l1a_write_back_data / l1b_write_back_data  in  LINE_WIDTH  write-back line
l2_address  out  ADDRESS_WIDTH  address to L2
l2_read_req / l2_write_req / l2_write_back_req  out  1  forwarded request, granted requester only
l2_write_back_data  out  LINE_WIDTH  forwarded line
L2_ready / write_to_L2_verified / write_back_to_L2_verified  in  1  L2 completion strobes
l2_read_data  in  LINE_WIDTH  line from L2
l1a_L2_ready / l1b_L2_ready, l1a_write_verified / l1b_write_verified, l1a_write_back_verified / l1b_write_back_verified  out  1  routed completion strobes
l1_read_data  out  LINE_WIDTH  l2_read_data broadcast to both L1s (qualified by the routed ready)
grant_id  out  1  0 = L1a, 1 = L1b; valid while busy
arb_busy  out  1  high in GRANT
timeout_error  out  1  sticky watchdog flag

Behaviour:
- States: IDLE, GRANT, RELEASE, held in a 2-bit registered state.
- Reset:
  - state IDLE, round-robin pointer rr = 0 (L1a first), grant_id = 0, latched type = none, timeout_error = 0, counter = 0.
  - All l2_* requests and all routed strobes are 0; l2_address and l2_write_back_data are 0.
  - A reset asserted mid-transaction aborts it; no strobe is routed in the reset cycle.
- A requester is active when any of its read, write or write_back requests is high.
- Within one requester, if more than one type is high, the latched type priority is write_back > write > read.
- IDLE:
  - Only one requester active: grant it.
  - Both active: grant rr.
  - On a grant, register grant_id and the request type, then go to GRANT.
- GRANT:
  - Latency is one cycle: a request sampled in IDLE at edge N is driven on the l2_* port from cycle N+1.
  - l2_address and l2_write_back_data are driven live (combinationally) from the granted requester's inputs.
  - Only the l2_* request of the latched type is asserted, and only while the granted requester still holds it.
  - The non-granted requester's inputs are ignored.
  - Routed completion strobes are combinational, type-matched and granted-only:
    - L2_ready goes to lX_L2_ready, only when the latched type is read.
    - write_to_L2_verified goes to lX_write_verified, only when the type is write.
    - write_back_to_L2_verified goes to lX_write_back_verified, only when the type is write_back.
    - A mismatched-type strobe is dropped and does not complete the transaction.
  - Completion (the matched strobe high): next state RELEASE, and rr is set to the non-granted requester.
  - Abort (the granted requester drops its latched request with no strobe): next state RELEASE, rr unchanged.
  - Completion and abort in the same cycle counts as completion.
- RELEASE:
  - One cycle with all l2_* requests at 0 and all strobes at 0, so the L2 FSM can return to idle.
  - Always goes to IDLE.
  - New requests are not sampled until IDLE, so back-to-back transactions occupy at least 3 cycles each.
- arb_busy is 1 only in GRANT.
- grant_id holds its last value outside GRANT.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- When defined:
  - An 8-bit-or-wider counter clears on entry to GRANT and increments each GRANT cycle.
  - When the counter reaches TIMEOUT_CYCLES with no completion, timeout_error is set (sticky until reset), the FSM goes to RELEASE and rr advances.
  - No strobe is routed on timeout.
- When undefined: no counter is built, timeout_error is tied to 0, and GRANT waits indefinitely.

Test Plan:
- Reset, then L1a asserts read_req with address 0x0000_0040; L2_ready is pulsed 4 cycles after grant -> l2_read_req is high from cycle 1, l1a_L2_ready pulses once, l1b_L2_ready stays 0, the FSM passes through RELEASE (l2_read_req = 0), and rr = 1.
- L1a and L1b both assert read in the same cycle after reset -> L1a is granted first and then L1b; the next simultaneous pair is granted to L1a again (strict alternation across 4 transactions).
- L1b asserts write_back_req and read_req together with line 0xDEAD...BEEF -> only l2_write_back_req is forwarded with that data; a stray L2_ready is not routed and the FSM stays in GRANT until write_back_to_L2_verified.
- L1a is granted for write; L1a drops write_req before any verify -> the FSM goes to RELEASE then IDLE, no strobe is routed, and rr stays 0.
- Reset is asserted during GRANT for L1b -> the next cycle is IDLE, all outputs are 0, grant_id = 0, and a pending L1b request is re-granted 1 cycle after reset is released.
- With ARB_TIMEOUT_EN and TIMEOUT_CYCLES = 8, L1a reads and the L2 never responds -> timeout_error is set after the 8th GRANT cycle, the FSM releases, and L1b is then granted; without the macro the FSM stays in GRANT for 100+ cycles and timeout_error stays 0.
